// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
// Optional FETCH_PERF_COUNTERS_EN adds the fetch_count / bubble_count outputs.
interface fetch_stage_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [PC_W-1:0]    if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic               if_id_valid;
    logic               misalign_err;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]        fetch_count;
    logic [31:0]        bubble_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign_err,
        output fetch_count, bubble_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign_err,
        input  fetch_count, bubble_count
    );
`else
    modport master (
        input  stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign_err
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, if_id_pc, if_id_instr, if_id_valid, misalign_err
    );
`endif
endinterface

// File: rtl/fetch_stage.sv
// ARMv8 instruction-fetch stage: PC register, imem address and IF/ID pipeline register.
// Optional FETCH_PERF_COUNTERS_EN adds saturating fetch/bubble performance counters.
module fetch_stage #(
    parameter int                PC_W     = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD = 32'hD503201F
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic               if_id_valid;
    logic               misalign_err;

    assign bus.imem_addr    = pc;
    assign bus.if_id_pc     = if_id_pc;
    assign bus.if_id_instr  = if_id_instr;
    assign bus.if_id_valid  = if_id_valid;
    assign bus.misalign_err = misalign_err;

    // Priority: reset > redirect > stall > normal sequencing.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_WORD;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else if (bus.redirect) begin
            // The wrong-path word at imem_rdata is dropped and replaced by a bubble.
            pc          <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            if_id_pc    <= pc;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else if (!bus.stall) begin
            pc          <= pc + PC_W'(4);
            if_id_pc    <= pc;
            if_id_instr <= bus.imem_rdata;
            if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    assign bus.fetch_count  = fetch_count;
    assign bus.bubble_count = bubble_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else if (bus.redirect || bus.stall) begin
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end else if (fetch_count != '1) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a behavioural model.
// Counter checks are compiled in when FETCH_PERF_COUNTERS_EN is defined.
module tb_fetch_stage;

    localparam int          PC_W = 64;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Instruction memory: a fixed word per address, 0x8B020020 at address 0.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return 32'h8B020020 ^ (lo * 32'h9E3779B1);
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Behavioural model state
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_mis;
    longint      m_fetch, m_bubble;

    // Drive one cycle of inputs, advance the model, return at the falling edge.
    task automatic step(input logic r, input logic s, input logic d, input logic [63:0] rpc);
        reset           = r;
        bus.stall       = s;
        bus.redirect    = d;
        bus.redirect_pc = rpc;
        @(posedge clock);
        if (r) begin
            m_pc = 64'h0; m_ipc = 64'h0; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
            m_fetch = 0; m_bubble = 0;
        end else if (d) begin
            m_ipc   = m_pc;
            m_pc    = rpc - (rpc % 4);
            m_instr = NOP;
            m_valid = 1'b0;
            if (rpc % 4 != 0) m_mis = 1'b1;
            if (m_bubble < 64'hFFFF_FFFF) m_bubble++;
        end else if (s) begin
            if (m_bubble < 64'hFFFF_FFFF) m_bubble++;
        end else begin
            m_ipc   = m_pc;
            m_instr = mem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            if (m_fetch < 64'hFFFF_FFFF) m_fetch++;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 64'h123);
        checks++;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin
            errors++;
            $display("FAIL reset_ifid: valid=%0b instr=%h, want valid=0 instr=%h", bus.if_id_valid, bus.if_id_instr, NOP);
        end
        checks++;
        if (bus.imem_addr !== 64'h0 || bus.misalign_err !== 1'b0 || bus.if_id_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_pc: addr=%h mis=%0b ifpc=%h, want 0 0 0", bus.imem_addr, bus.misalign_err, bus.if_id_pc);
        end
        step(0, 0, 0, 0);
        checks++;
        if (bus.if_id_pc !== 64'h0 || bus.if_id_instr !== 32'h8B020020 || bus.if_id_valid !== 1'b1 || bus.imem_addr !== 64'h4) begin
            errors++;
            $display("FAIL first_fetch: ifpc=%h instr=%h valid=%0b addr=%h, want 0 8b020020 1 4",
                     bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.imem_addr);
        end
    endtask

    task automatic test_straight_line();
        step(1, 0, 0, 0);
        for (int i = 0; i <= 5; i++) begin
            checks++;
            if (bus.imem_addr !== 64'(4 * i)) begin
                errors++;
                $display("FAIL line_addr[%0d]: got %h want %h", i, bus.imem_addr, 64'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (bus.if_id_pc !== 64'(4 * (i - 1)) || bus.if_id_instr !== mem_word(64'(4 * (i - 1)))) begin
                    errors++;
                    $display("FAIL line_ifid[%0d]: pc=%h instr=%h want pc=%h", i, bus.if_id_pc, bus.if_id_instr, 64'(4 * (i - 1)));
                end
            end
            if (i < 5) step(0, 0, 0, 0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        held = mem_word(64'h4);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            checks++;
            if (bus.imem_addr !== 64'h8 || bus.if_id_pc !== 64'h4 || bus.if_id_instr !== held || bus.if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: addr=%h ifpc=%h instr=%h valid=%0b, want 8 4 %h 1",
                         i, bus.imem_addr, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, held);
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (bus.imem_addr !== 64'hC || bus.if_id_pc !== 64'h8) begin
            errors++;
            $display("FAIL stall_resume: addr=%h ifpc=%h, want c 8", bus.imem_addr, bus.if_id_pc);
        end
    endtask

    task automatic test_stall_redirect();
        step(0, 1, 1, 64'h40);
        checks++;
        if (bus.imem_addr !== 64'h40 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP || bus.if_id_pc !== 64'hC) begin
            errors++;
            $display("FAIL redirect_flush: addr=%h valid=%0b instr=%h ifpc=%h, want 40 0 %h c",
                     bus.imem_addr, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, NOP);
        end
        step(0, 0, 0, 0);
        checks++;
        if (bus.if_id_pc !== 64'h40 || bus.if_id_valid !== 1'b1 || bus.if_id_instr !== mem_word(64'h40)) begin
            errors++;
            $display("FAIL redirect_resume: ifpc=%h valid=%0b instr=%h, want 40 1 %h",
                     bus.if_id_pc, bus.if_id_valid, bus.if_id_instr, mem_word(64'h40));
        end
    endtask

    task automatic test_misalign();
        checks++;
        if (bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_idle: got %0b want 0", bus.misalign_err);
        end
        step(0, 0, 1, 64'h42);
        checks++;
        if (bus.imem_addr !== 64'h40 || bus.misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_set: addr=%h mis=%0b, want 40 1", bus.imem_addr, bus.misalign_err);
        end
        step(0, 0, 1, 64'h100);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (bus.misalign_err !== 1'b1 || bus.imem_addr !== 64'h104) begin
            errors++;
            $display("FAIL misalign_sticky: mis=%0b addr=%h, want 1 104", bus.misalign_err, bus.imem_addr);
        end
        step(1, 0, 0, 0);
        checks++;
        if (bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_clear: got %0b want 0", bus.misalign_err);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 0, 0, 0);
        step(0, 0, 1, 64'h200);
        step(0, 0, 1, 64'h300);
        checks++;
        if (bus.imem_addr !== 64'h300 || bus.if_id_pc !== 64'h200 || bus.if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_redirect: addr=%h ifpc=%h valid=%0b, want 300 200 0", bus.imem_addr, bus.if_id_pc, bus.if_id_valid);
        end
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        step(0, 0, 0, 0);
        checks++;
        if (bus.imem_addr !== 64'h0 || bus.if_id_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL pc_wrap: addr=%h ifpc=%h, want 0 fffffffffffffffc", bus.imem_addr, bus.if_id_pc);
        end
    endtask

    task automatic test_random();
        logic        r, s, d;
        logic [63:0] rpc;
        step(1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 49) == 0);
            s   = ($urandom_range(0, 3) == 0);
            d   = ($urandom_range(0, 5) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7))
                                              : {32'($urandom), 32'($urandom)};
            step(r, s, d, rpc);
            checks++;
            if (bus.imem_addr !== m_pc || bus.if_id_pc !== m_ipc || bus.if_id_instr !== m_instr ||
                bus.if_id_valid !== m_valid || bus.misalign_err !== m_mis) begin
                errors++;
                $display("FAIL random[%0d]: addr=%h ifpc=%h instr=%h v=%0b mis=%0b, want %h %h %h %0b %0b",
                         i, bus.imem_addr, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.misalign_err,
                         m_pc, m_ipc, m_instr, m_valid, m_mis);
            end
`ifdef FETCH_PERF_COUNTERS_EN
            checks++;
            if (bus.fetch_count !== 32'(m_fetch) || bus.bubble_count !== 32'(m_bubble)) begin
                errors++;
                $display("FAIL random_cnt[%0d]: fetch=%0d bubble=%0d, want %0d %0d",
                         i, bus.fetch_count, bus.bubble_count, m_fetch, m_bubble);
            end
`endif
        end
    endtask

`ifdef FETCH_PERF_COUNTERS_EN
    task automatic test_perf_counters();
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 64'h80);
        checks++;
        if (bus.fetch_count !== 32'd10 || bus.bubble_count !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts: fetch=%0d bubble=%0d, want 10 3", bus.fetch_count, bus.bubble_count);
        end
        step(1, 1, 1, 64'h44);
        checks++;
        if (bus.fetch_count !== 32'd0 || bus.bubble_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: fetch=%0d bubble=%0d, want 0 0", bus.fetch_count, bus.bubble_count);
        end
    endtask
`endif

    initial begin
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        @(negedge clock);
        test_reset();
        test_straight_line();
        test_stall();
        test_stall_redirect();
        test_misalign();
        test_back_to_back();
        test_random();
`ifdef FETCH_PERF_COUNTERS_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
